descrambler_unpack: RTL and testbench

- Downstream consumer of the 4-phase nibble scrambler stage.
- The scrambler applies a repeating 4-phase transform to each nibble: phase 0 inverts, phases 1–3 rotate left by 1, 2 and 3.
- This block tracks the same phase, applies the inverse transform to each incoming nibble, and packs WORD_NIBBLES recovered nibbles into one word.
- Words leave through a 2-entry valid/ready buffer; an overflow flag reports dropped words.

---
 rtl/descr_pkg.sv | 28 ++
 rtl/descr_word_fifo.sv | 68 ++++++
 rtl/descrambler_unpack.sv | 112 +++++++++++
 tb/tb_descrambler_unpack.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/descr_pkg.sv
// Shared widths, phase encoding and the inverse nibble transform for the
// 4-phase nibble descrambler.
package descr_pkg;

    localparam int PHASE_W = 2;
    localparam int NIB_W   = 4;

    typedef enum logic [PHASE_W-1:0] {
        PH_INV = 2'd0,
        PH_R1  = 2'd1,
        PH_R2  = 2'd2,
        PH_R3  = 2'd3
    } phase_e;

    // Undoes the upstream transform: inversion, or rotate right by the phase
    function automatic logic [NIB_W-1:0] descr_inv(input logic [NIB_W-1:0] d,
                                                   input phase_e ph);
        logic [NIB_W-1:0] r;
        case (ph)
            PH_INV:  r = ~d;
            PH_R1:   r = {d[0], d[3:1]};
            PH_R2:   r = {d[1:0], d[3:2]};
            default: r = {d[2:0], d[3]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/descr_word_fifo.sv
// Two-entry valid/ready word buffer with full and drop reporting.
// Entry 0 is always the head; a push into a full buffer without a pop is dropped.
module descr_word_fifo
    import descr_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         full,
    output logic         drop
);

    logic [W-1:0] mem0_q;
    logic [W-1:0] mem1_q;
    logic [1:0]   count_q;
    logic         pop;

    assign valid = (count_q != 2'd0);
    assign full  = (count_q == 2'd2);
    assign pop   = valid & ready;
    assign drop  = push & full & ~pop;
    assign head  = mem0_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        mem0_q  <= push_data;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    // With a pop the new word replaces the departing head
                    if (push && pop) begin
                        mem0_q <= push_data;
                    end else if (push) begin
                        mem1_q  <= push_data;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        mem0_q <= mem1_q;
                        if (push) begin
                            mem1_q <= push_data;
                        end else begin
                            count_q <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/descrambler_unpack.sv
// Tracks the scrambler phase, recovers each nibble and packs WORD_NIBBLES of
// them into a word for the output buffer. DESCR_PARITY_EN adds dout_parity.
module descrambler_unpack
    import descr_pkg::*;
#(
    parameter  int WORD_NIBBLES = 4,
    localparam int DW           = NIB_W * WORD_NIBBLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NIB_W-1:0] din,
    input  logic             din_valid,
    input  logic             phase_sync,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    input  logic             dout_ready,
`ifdef DESCR_PARITY_EN
    output logic             dout_parity,
`endif
    output logic             overflow
);

`ifdef DESCR_PARITY_EN
    localparam int FW = DW + 1;
`else
    localparam int FW = DW;
`endif

    logic [PHASE_W-1:0] phase_q;
    logic [2:0]         cnt_q;
    logic [DW-1:0]      pack_q;
    logic               push_q;
    logic [FW-1:0]      push_data_q;

    logic [PHASE_W-1:0] eff_phase;
    logic [2:0]         idx;
    logic [NIB_W-1:0]   nib;
    logic [DW-1:0]      pack_next;
    logic [FW-1:0]      word_in;
    logic               word_done;

    logic [FW-1:0]      fifo_head;
    logic               fifo_full;
    logic               fifo_drop;

    always_comb begin
        eff_phase = phase_sync ? '0 : phase_q;
        idx       = phase_sync ? 3'd0 : cnt_q;
        nib       = descr_inv(din, phase_e'(eff_phase));
        // A sync drops whatever partial word was being assembled
        pack_next = phase_sync ? '0 : pack_q;
        pack_next[idx*NIB_W +: NIB_W] = nib;
        word_done = din_valid && (idx == 3'(WORD_NIBBLES - 1));
`ifdef DESCR_PARITY_EN
        word_in   = {^pack_next, pack_next};
`else
        word_in   = pack_next;
`endif
    end

    // Completed words are staged one cycle before entering the buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= '0;
            cnt_q       <= 3'd0;
            pack_q      <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            overflow    <= 1'b0;
        end else begin
            push_q <= word_done;
            if (word_done) begin
                push_data_q <= word_in;
            end
            if (din_valid) begin
                phase_q <= eff_phase + 1'b1;
                if (word_done) begin
                    cnt_q  <= 3'd0;
                    pack_q <= '0;
                end else begin
                    cnt_q  <= idx + 3'd1;
                    pack_q <= pack_next;
                end
            end
            if (fifo_full && fifo_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    descr_word_fifo #(
        .W (FW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (push_data_q),
        .ready     (dout_ready),
        .head      (fifo_head),
        .valid     (dout_valid),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

`ifdef DESCR_PARITY_EN
    assign dout        = fifo_head[DW-1:0];
    assign dout_parity = fifo_head[DW];
`else
    assign dout        = fifo_head;
`endif

endmodule

// File: tb/tb_descrambler_unpack.sv
// Directed self-checking bench for descrambler_unpack (WORD_NIBBLES=4).
module tb_descrambler_unpack;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  din;
    logic        din_valid;
    logic        phase_sync;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        overflow;
`ifdef DESCR_PARITY_EN
    logic        dout_parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    descrambler_unpack #(.WORD_NIBBLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .phase_sync (phase_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef DESCR_PARITY_EN
        .dout_parity(dout_parity),
`endif
        .overflow   (overflow)
    );

    // Called at a falling edge; presents one nibble for the next rising edge
    task automatic nib(input logic [3:0] d, input logic s);
        din = d; din_valid = 1'b1; phase_sync = s;
        @(negedge clk);
        din_valid = 1'b0; phase_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scrambled forms: A=E,4,C,2 -> 4321  B=A,C,D,4 -> 8765  C=6,5,E,6 -> CBA9
    task automatic word_a(input logic s);
        nib(4'hE, s); nib(4'h4, 1'b0); nib(4'hC, 1'b0); nib(4'h2, 1'b0);
    endtask
    task automatic word_b();
        nib(4'hA, 1'b0); nib(4'hC, 1'b0); nib(4'hD, 1'b0); nib(4'h4, 1'b0);
    endtask
    task automatic word_c();
        nib(4'h6, 1'b0); nib(4'h5, 1'b0); nib(4'hE, 1'b0); nib(4'h6, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle(1);
        n_checks++; if (dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0000", dout); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", dout_valid); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
`ifdef DESCR_PARITY_EN
        n_checks++; if (dout_parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity got %b want 0", dout_parity); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_recovery();
        dout_ready = 1'b0;
        word_a(1'b1);
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL recov_latency_early got %b want 0", dout_valid); end
        idle(1);
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL recov_valid got %b want 1", dout_valid); end
        n_checks++; if (dout !== 16'h4321) begin n_fail++; $display("FAIL recov_dout got %h want 4321", dout); end
`ifdef DESCR_PARITY_EN
        n_checks++; if (dout_parity !== 1'b1) begin n_fail++; $display("FAIL recov_parity got %b want 1", dout_parity); end
`endif
        idle(2);
        n_checks++; if (dout !== 16'h4321) begin n_fail++; $display("FAIL recov_hold got %h want 4321", dout); end
        dout_ready = 1'b1;
        idle(1);
        dout_ready = 1'b0;
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL recov_pop got %b want 0", dout_valid); end
    endtask

    task automatic test_phase_hold();
        nib(4'hE, 1'b1); idle(3);
        nib(4'h4, 1'b0); idle(3);
        nib(4'hC, 1'b0); idle(3);
        nib(4'h2, 1'b0); idle(1);
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid got %b want 1", dout_valid); end
        n_checks++; if (dout !== 16'h4321) begin n_fail++; $display("FAIL hold_dout got %h want 4321", dout); end
        dout_ready = 1'b1;
        idle(1);
        dout_ready = 1'b0;
    endtask

    task automatic test_resync();
        nib(4'hE, 1'b1); nib(4'h4, 1'b0);
        word_a(1'b1);
        idle(1);
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL resync_valid got %b want 1", dout_valid); end
        n_checks++; if (dout !== 16'h4321) begin n_fail++; $display("FAIL resync_dout got %h want 4321", dout); end
        dout_ready = 1'b1;
        idle(1);
        dout_ready = 1'b0;
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL resync_single got %b want 0", dout_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        dout_ready = 1'b0;
        word_a(1'b1); word_b(); word_c();
        idle(2);
        n_checks++; if (dout !== 16'h4321) begin n_fail++; $display("FAIL bp_head got %h want 4321", dout); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got %b want 1", overflow); end
        dout_ready = 1'b1;
        idle(1);
        n_checks++; if (dout !== 16'h8765) begin n_fail++; $display("FAIL bp_second got %h want 8765", dout); end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid got %b want 1", dout_valid); end
        idle(1);
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b want 0", dout_valid); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got %b want 1", overflow); end
        dout_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        dout_ready = 1'b0;
        word_a(1'b1); word_b();
        idle(1);
        n_checks++; if (dout !== 16'h4321) begin n_fail++; $display("FAIL fpp_head got %h want 4321", dout); end
        word_c();
        dout_ready = 1'b1;
        idle(1);
        n_checks++; if (dout !== 16'h8765) begin n_fail++; $display("FAIL fpp_second got %h want 8765", dout); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_no_drop got %b want 0", overflow); end
        idle(1);
        n_checks++; if (dout !== 16'hCBA9) begin n_fail++; $display("FAIL fpp_third got %h want cba9", dout); end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL fpp_third_valid got %b want 1", dout_valid); end
        idle(1);
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_drained got %b want 0", dout_valid); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow_end got %b want 0", overflow); end
        dout_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        dout_ready = 1'b0;
        word_a(1'b1); word_b(); word_c();
        nib(4'hE, 1'b1); nib(4'h4, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ar_pre_overflow got %b want 1", overflow); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (dout !== 16'h0) begin n_fail++; $display("FAIL ar_dout got %h want 0000", dout); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %b want 0", dout_valid); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ar_overflow got %b want 0", overflow); end
        @(negedge clk);
        reset = 1'b0;
        word_a(1'b1);
        idle(1);
        n_checks++; if (dout !== 16'h4321) begin n_fail++; $display("FAIL ar_restart got %h want 4321", dout); end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL ar_restart_valid got %b want 1", dout_valid); end
`ifdef DESCR_PARITY_EN
        n_checks++; if (dout_parity !== 1'b1) begin n_fail++; $display("FAIL ar_parity got %b want 1", dout_parity); end
`endif
        dout_ready = 1'b1;
        idle(1);
        dout_ready = 1'b0;
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL ar_single got %b want 0", dout_valid); end
    endtask

    initial begin
        reset      = 1'b1;
        din        = 4'h0;
        din_valid  = 1'b0;
        phase_sync = 1'b0;
        dout_ready = 1'b0;
        test_reset();
        test_recovery();
        test_phase_hold();
        test_resync();
        test_backpressure();
        test_full_push_pop();
        test_async_reset();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
